// File: rtl/dm_bytelane_mem.sv
// Byte-lane data memory for the MEM stage: byte/half/word loads and stores, registered
// responses with RD_LAT latency, misalignment errors and a post-reset zero-fill engine.
module dm_bytelane_mem #(
   parameter int unsigned DEPTH        = 1024,
   parameter int unsigned ADDR_W       = $clog2(DEPTH) + 2,
   parameter int unsigned RD_LAT       = 1,
   parameter bit          CLEAR_ON_RST = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              init_done
);

   localparam int unsigned IDX_W = $clog2(DEPTH);

   typedef enum logic {StClear, StIdle} state_e;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic             init_done_q, init_done_d;

   logic [31:0]      mem [DEPTH];

   logic [IDX_W-1:0] idx;
   logic [1:0]       lane;
   logic             accept;
   logic             req_err;
   logic [3:0]       be;
   logic [31:0]      wdata_rep;
   logic [31:0]      rd_word;
   logic [31:0]      shifted;
   logic [31:0]      load_data;
   logic [31:0]      rdata_d;

   assign idx       = req_addr[ADDR_W-1:2];
   assign lane      = req_addr[1:0];
   assign req_ready = init_done_q;
   assign init_done = init_done_q;
   assign accept    = req_valid & init_done_q;

   always_comb begin
      req_err   = 1'b0;
      be        = 4'b0000;
      wdata_rep = req_wdata;
      unique case (req_size)
         2'b00: begin
            be        = 4'b0001 << lane;
            wdata_rep = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            req_err   = lane[0];
            be        = lane[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{req_wdata[15:0]}};
         end
         2'b10: begin
            req_err = (lane != 2'b00);
            be      = 4'b1111;
         end
         default: req_err = 1'b1;
      endcase
   end

   // Zero-fill engine: one word per cycle until the last index, then serve requests.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      init_done_d = init_done_q;
      unique case (state_q)
         StClear: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == IDX_W'(DEPTH - 1)) begin
               state_d     = StIdle;
               init_done_d = 1'b1;
            end
         end
         StIdle: init_done_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         if (CLEAR_ON_RST) state_q <= StClear;
         else              state_q <= StIdle;
         cnt_q       <= '0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         init_done_q <= init_done_d;
      end
   end

   // Array has no reset; the fill engine and stores are its only writers.
   always_ff @(posedge clk) begin
      if (state_q == StClear) begin
         mem[cnt_q] <= '0;
      end else if (accept && req_we && !req_err) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
         end
      end
   end

   always_comb begin
      rd_word = mem[idx];
      shifted = rd_word >> {lane, 3'b000};
      unique case (req_size)
         2'b00:   load_data = {{24{~req_unsigned & shifted[7]}}, shifted[7:0]};
         2'b01:   load_data = {{16{~req_unsigned & shifted[15]}}, shifted[15:0]};
         default: load_data = rd_word;
      endcase
      rdata_d = (req_we || req_err) ? 32'h0 : load_data;
   end

   logic        s1_valid_q;
   logic [31:0] s1_rdata_q;
   logic        s1_err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid_q <= 1'b0;
         s1_rdata_q <= '0;
         s1_err_q   <= 1'b0;
      end else begin
         s1_valid_q <= accept;
         s1_rdata_q <= accept ? rdata_d : 32'h0;
         s1_err_q   <= accept & req_err;
      end
   end

   if (RD_LAT == 2) begin : g_lat2
      logic        s2_valid_q;
      logic [31:0] s2_rdata_q;
      logic        s2_err_q;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            s2_valid_q <= 1'b0;
            s2_rdata_q <= '0;
            s2_err_q   <= 1'b0;
         end else begin
            s2_valid_q <= s1_valid_q;
            s2_rdata_q <= s1_rdata_q;
            s2_err_q   <= s1_err_q;
         end
      end

      assign rsp_valid = s2_valid_q;
      assign rsp_rdata = s2_rdata_q;
      assign rsp_err   = s2_err_q;
   end else begin : g_lat1
      assign rsp_valid = s1_valid_q;
      assign rsp_rdata = s1_rdata_q;
      assign rsp_err   = s1_err_q;
   end

endmodule

// File: tb/tb_dm_bytelane_mem.sv
// Bench for dm_bytelane_mem: RD_LAT=1 and RD_LAT=2 instances share stimulus and are checked
// every cycle against a byte-array reference model with per-instance response queues.
module tb_dm_bytelane_mem;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned AW    = 6;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_we = 1'b0;
   logic          req_unsigned = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [1:0]    req_size = '0;
   logic [31:0]   req_wdata = '0;

   logic        rdy1, rdy2, rv1, rv2, re1, re2, id1, id2;
   logic [31:0] rd1, rd2;

   always #5 clk = ~clk;

   dm_bytelane_mem #(.DEPTH(DEPTH), .RD_LAT(1), .CLEAR_ON_RST(1'b1)) u_dut1 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1), .req_we(req_we),
      .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_wdata(req_wdata), .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(re1), .init_done(id1)
   );

   dm_bytelane_mem #(.DEPTH(DEPTH), .RD_LAT(2), .CLEAR_ON_RST(1'b1)) u_dut2 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy2), .req_we(req_we),
      .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_wdata(req_wdata), .rsp_valid(rv2), .rsp_rdata(rd2), .rsp_err(re2), .init_done(id2)
   );

   typedef struct {
      int          due;
      logic [31:0] rdata;
      logic        err;
      logic        has_lit;
      logic [31:0] lit;
   } exp_t;

   exp_t        q1[$];
   exp_t        q2[$];
   exp_t        pe, e1, e2;
   logic        h1, h2;
   logic [7:0]  mb [4*DEPTH];
   int          cyc = 0;
   int          rel_cnt = 0;
   int          errors = 0;
   int          checks = 0;
   logic        cur_has_lit = 1'b0;
   logic [31:0] cur_lit = '0;

   int          nb, a;
   logic        merr;
   logic [31:0] val, tmp;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Reference model: byte-addressed array, responses queued with their due cycle.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         q1.delete();
         q2.delete();
         rel_cnt = 0;
         for (int i = 0; i < 4 * DEPTH; i++) mb[i] = 8'h00;
      end else begin
         cyc++;
         if (req_valid && rel_cnt >= int'(DEPTH)) begin
            a    = int'(req_addr);
            nb   = 1 << req_size;
            merr = (req_size == 2'd3) || ((a % nb) != 0);
            val  = 32'h0;
            if (!merr && req_we) begin
               for (int i = 0; i < nb; i++) begin
                  tmp = req_wdata >> (8 * i);
                  mb[a+i] = tmp[7:0];
               end
            end else if (!merr) begin
               for (int i = 0; i < nb; i++) val = val | (32'(mb[a+i]) << (8 * i));
               if (nb < 4 && !req_unsigned && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8 * nb));
            end
            pe.rdata   = val;
            pe.err     = merr;
            pe.has_lit = cur_has_lit;
            pe.lit     = cur_lit;
            pe.due     = cyc;
            q1.push_back(pe);
            pe.due     = cyc + 1;
            q2.push_back(pe);
         end
         if (rel_cnt < 1000) rel_cnt++;
      end
   end

   task automatic rsp_cmp(input string tag, input logic ev, input exp_t e, input logic v,
                          input logic [31:0] d, input logic er);
      check({tag, " rsp_valid"}, 32'(v), 32'(ev));
      if (ev) begin
         check({tag, " rsp_rdata"}, d, e.rdata);
         check({tag, " rsp_err"}, 32'(er), 32'(e.err));
         if (e.has_lit) check({tag, " literal"}, d, e.lit);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         check("rst ready1", 32'(rdy1), 32'h0);
         check("rst ready2", 32'(rdy2), 32'h0);
         check("rst valid1", 32'(rv1), 32'h0);
         check("rst valid2", 32'(rv2), 32'h0);
         check("rst rdata1", rd1, 32'h0);
         check("rst err2", 32'(re2), 32'h0);
         check("rst init1", 32'(id1), 32'h0);
      end else begin
         check("ready1", 32'(rdy1), 32'(rel_cnt >= int'(DEPTH)));
         check("ready2", 32'(rdy2), 32'(rel_cnt >= int'(DEPTH)));
         check("init1", 32'(id1), 32'(rel_cnt >= int'(DEPTH)));
         check("init2", 32'(id2), 32'(rel_cnt >= int'(DEPTH)));
         h1 = (q1.size() > 0) && (q1[0].due == cyc);
         h2 = (q2.size() > 0) && (q2[0].due == cyc);
         e1 = '{default: '0};
         e2 = '{default: '0};
         if (h1) e1 = q1.pop_front();
         if (h2) e2 = q2.pop_front();
         rsp_cmp("lat1", h1, e1, rv1, rd1, re1);
         rsp_cmp("lat2", h2, e2, rv2, rd2, re2);
      end
   end

   task automatic issue(input logic we, input int addr, input logic [1:0] size, input logic uns,
                        input logic [31:0] wd, input logic hl, input logic [31:0] lit);
      @(posedge clk);
      #1;
      req_valid    = 1'b1;
      req_we       = we;
      req_addr     = AW'(addr);
      req_size     = size;
      req_unsigned = uns;
      req_wdata    = wd;
      cur_has_lit  = hl;
      cur_lit      = lit;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         req_valid   = 1'b0;
         cur_has_lit = 1'b0;
      end
   endtask

   task automatic wait_init(input string tag);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!(id1 && id2) && n < 100);
      check({tag, " init cycles"}, 32'(n), 32'(DEPTH));
      check({tag, " init_done1"}, 32'(id1), 32'h1);
      check({tag, " init_done2"}, 32'(id2), 32'h1);
   endtask

   initial begin
      int          r;
      int          ad;
      logic [1:0]  sz;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      wait_init("reset");

      issue(1'b0, 'h3C, 2'd2, 1'b0, 32'h0, 1'b1, 32'h0);
      issue(1'b1, 'h0, 2'd2, 1'b0, 32'h8081_7F80, 1'b1, 32'h0);
      issue(1'b0, 'h0, 2'd0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FF80);
      issue(1'b0, 'h1, 2'd0, 1'b1, 32'h0, 1'b1, 32'h0000_007F);
      issue(1'b0, 'h2, 2'd1, 1'b0, 32'h0, 1'b1, 32'hFFFF_8081);
      issue(1'b0, 'h2, 2'd1, 1'b1, 32'h0, 1'b1, 32'h0000_8081);
      issue(1'b1, 'h4, 2'd2, 1'b0, 32'h1122_3344, 1'b1, 32'h0);
      issue(1'b1, 'h5, 2'd0, 1'b0, 32'hFFFF_FFAA, 1'b1, 32'h0);
      issue(1'b1, 'h6, 2'd1, 1'b0, 32'h1234_BEEF, 1'b1, 32'h0);
      issue(1'b0, 'h4, 2'd2, 1'b1, 32'h0, 1'b1, 32'hBEEF_AA44);
      issue(1'b0, 'h1, 2'd1, 1'b0, 32'h0, 1'b1, 32'h0);
      issue(1'b1, 'h2, 2'd2, 1'b0, 32'h1234_5678, 1'b1, 32'h0);
      issue(1'b0, 'h0, 2'd3, 1'b0, 32'h0, 1'b1, 32'h0);
      issue(1'b0, 'h0, 2'd2, 1'b0, 32'h0, 1'b1, 32'h8081_7F80);
      idle(3);
      issue(1'b1, 'h8, 2'd2, 1'b0, 32'hDEAD_BEEF, 1'b1, 32'h0);
      issue(1'b0, 'h8, 2'd2, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
      idle(4);

      // Reset with a load in flight, then again part-way through the fill.
      issue(1'b0, 'h8, 2'd2, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
      @(posedge clk);
      #1;
      req_valid   = 1'b0;
      cur_has_lit = 1'b0;
      rst         = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      repeat (5) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      wait_init("refill");
      issue(1'b0, 'h8, 2'd2, 1'b0, 32'h0, 1'b1, 32'h0);
      idle(2);

      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            idle(1);
         end else begin
            r  = int'($urandom_range(0, 15));
            sz = (r == 15) ? 2'd3 : 2'(r % 3);
            ad = int'($urandom_range(0, 4 * DEPTH - 1));
            if (sz != 2'd3 && $urandom_range(0, 3) != 0) ad = ad & ~((1 << sz) - 1);
            issue(1'($urandom_range(0, 1)), ad, sz, 1'($urandom_range(0, 1)), $urandom,
                  1'b0, 32'h0);
         end
      end
      idle(5);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
